// File: rtl/rob_pkg.sv
// Shared sizing constants and entry layout for the reorder buffer.
package rob_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned AREGS  = 8;
    localparam int unsigned AREG_W = 3;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AREG_W-1:0] Rw;
        logic [TAG_W-1:0]  tag_PRF;
        logic [TAG_W-1:0]  tag_old;
    } rob_entry_t;

    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/arch_rat.sv
// Architectural tag table: committed register-to-physical-tag mapping.
module arch_rat
    import rob_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AREG_W-1:0]            wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    output logic [AREGS-1:0][TAG_W-1:0]  ARF_tag
);

    // Identity mapping on reset: architectural register i lives in physical tag i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < AREGS; i++) begin
                ARF_tag[AREG_W'(i)] <= TAG_W'(i);
            end
        end else if (we) begin
            ARF_tag[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order retire.
module rob
    import rob_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stop,
    input  logic                         valid_issue,
    input  logic [AREG_W-1:0]            Rw,
    input  logic [TAG_W-1:0]             tag_PRF,
    input  logic [TAG_W-1:0]             tag_Rw_old,
    output logic [TAG_W-1:0]             tag_ROB,
    output logic                         full_ROB,
    output logic                         empty_ROB,
    input  logic                         valid_Result_add,
    input  logic [TAG_W-1:0]             tag_ROB_add,
    input  logic                         valid_Result_mul,
    input  logic [TAG_W-1:0]             tag_ROB_mul,
    output logic                         valid_commit,
    output logic [AREG_W-1:0]            commit_Rw,
    output logic [TAG_W-1:0]             commit_tag_PRF,
    output logic [TAG_W-1:0]             commit_tag_free,
    output logic [AREGS-1:0][TAG_W-1:0]  ARF_tag
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    rob_entry_t       entries [DEPTH];
    rob_entry_t       head_entry;
    rob_entry_t       new_entry;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic             alloc;
    logic             commit;

    assign full_ROB   = (count == FULL_COUNT);
    assign empty_ROB  = (count == '0);
    assign tag_ROB    = tail;
    assign alloc      = valid_issue && !stop && !full_ROB;
    assign head_entry = entries[head];
    assign commit     = head_entry.valid && head_entry.done;

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.done    = 1'b0;
        new_entry.Rw      = Rw;
        new_entry.tag_PRF = tag_PRF;
        new_entry.tag_old = tag_Rw_old;
    end

    always_comb begin
        valid_commit    = 1'b0;
        commit_Rw       = '0;
        commit_tag_PRF  = '0;
        commit_tag_free = '0;
        if (commit) begin
            valid_commit    = 1'b1;
            commit_Rw       = head_entry.Rw;
            commit_tag_PRF  = head_entry.tag_PRF;
            commit_tag_free = head_entry.tag_old;
        end
    end

    // Alloc can only target the head slot when the buffer is full (refused) or
    // empty (nothing to commit), so the commit clear and alloc write never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries[i].valid &&
                    ((valid_Result_add && tag_ROB_add == TAG_W'(i)) ||
                     (valid_Result_mul && tag_ROB_mul == TAG_W'(i)))) begin
                    entries[i].done <= 1'b1;
                end
            end
            if (commit) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
                head                <= ptr_inc(head);
            end
            if (alloc) begin
                entries[tail] <= new_entry;
                tail          <= ptr_inc(tail);
            end
            case ({alloc, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    arch_rat u_arch_rat (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .wr_idx  (commit_Rw),
        .wr_tag  (commit_tag_PRF),
        .ARF_tag (ARF_tag)
    );

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob against a queue-based reference model.
module tb_rob;
    import rob_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        stop = 1'b0;
    logic                        valid_issue = 1'b0;
    logic [AREG_W-1:0]           Rw = '0;
    logic [TAG_W-1:0]            tag_PRF = '0;
    logic [TAG_W-1:0]            tag_Rw_old = '0;
    logic [TAG_W-1:0]            tag_ROB;
    logic                        full_ROB;
    logic                        empty_ROB;
    logic                        valid_Result_add = 1'b0;
    logic [TAG_W-1:0]            tag_ROB_add = '0;
    logic                        valid_Result_mul = 1'b0;
    logic [TAG_W-1:0]            tag_ROB_mul = '0;
    logic                        valid_commit;
    logic [AREG_W-1:0]           commit_Rw;
    logic [TAG_W-1:0]            commit_tag_PRF;
    logic [TAG_W-1:0]            commit_tag_free;
    logic [AREGS-1:0][TAG_W-1:0] ARF_tag;

    rob dut (
        .clk              (clk),
        .rst              (rst),
        .stop             (stop),
        .valid_issue      (valid_issue),
        .Rw               (Rw),
        .tag_PRF          (tag_PRF),
        .tag_Rw_old       (tag_Rw_old),
        .tag_ROB          (tag_ROB),
        .full_ROB         (full_ROB),
        .empty_ROB        (empty_ROB),
        .valid_Result_add (valid_Result_add),
        .tag_ROB_add      (tag_ROB_add),
        .valid_Result_mul (valid_Result_mul),
        .tag_ROB_mul      (tag_ROB_mul),
        .valid_commit     (valid_commit),
        .commit_Rw        (commit_Rw),
        .commit_tag_PRF   (commit_tag_PRF),
        .commit_tag_free  (commit_tag_free),
        .ARF_tag          (ARF_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of in-flight instructions plus the tag of its oldest slot.
    typedef struct {
        int unsigned rw;
        int unsigned prf;
        int unsigned old;
        bit          done;
    } ment_t;

    ment_t       mq[$];
    int unsigned mhead;
    int unsigned marf[AREGS];

    logic                        exp_vc;
    logic [AREG_W-1:0]           exp_rw;
    logic [TAG_W-1:0]            exp_prf;
    logic [TAG_W-1:0]            exp_free;
    logic [TAG_W-1:0]            exp_tag;
    logic                        exp_full;
    logic                        exp_empty;
    logic [AREGS-1:0][TAG_W-1:0] exp_arf;
    logic [AREGS-1:0][TAG_W-1:0] ident;

    function automatic void model_reset();
        mq.delete();
        mhead = 0;
        for (int i = 0; i < AREGS; i++) marf[i] = i;
    endfunction

    function automatic void model_expect();
        exp_vc    = (mq.size() > 0) && mq[0].done;
        exp_rw    = exp_vc ? AREG_W'(mq[0].rw)  : '0;
        exp_prf   = exp_vc ? TAG_W'(mq[0].prf)  : '0;
        exp_free  = exp_vc ? TAG_W'(mq[0].old)  : '0;
        exp_tag   = TAG_W'((mhead + mq.size()) % DEPTH);
        exp_full  = (mq.size() == DEPTH);
        exp_empty = (mq.size() == 0);
        for (int i = 0; i < AREGS; i++) exp_arf[i] = TAG_W'(marf[i]);
    endfunction

    function automatic void model_complete(input int unsigned tag);
        int unsigned idx;
        idx = (tag + DEPTH - mhead) % DEPTH;
        if (idx < mq.size()) mq[idx].done = 1'b1;
    endfunction

    // One clock: model sees the inputs held across the rising edge, returns at the falling edge.
    task automatic step();
        bit do_commit;
        bit do_alloc;
        @(posedge clk);
        do_commit = (mq.size() > 0) && mq[0].done;
        do_alloc  = valid_issue && !stop && (mq.size() < DEPTH);
        if (valid_Result_add) model_complete(tag_ROB_add);
        if (valid_Result_mul) model_complete(tag_ROB_mul);
        if (do_commit) begin
            marf[mq[0].rw] = mq[0].prf;
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
        end
        if (do_alloc) mq.push_back('{rw: Rw, prf: tag_PRF, old: tag_Rw_old, done: 1'b0});
        @(negedge clk);
    endtask

    task automatic set_idle();
        stop             = 1'b0;
        valid_issue      = 1'b0;
        valid_Result_add = 1'b0;
        valid_Result_mul = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (tag_ROB !== 4'd0) begin n_fail++; $display("FAIL reset_tag_ROB: got %0d want 0", tag_ROB); end
        n_checks++;
        if ({full_ROB, empty_ROB} !== 2'b01) begin n_fail++; $display("FAIL reset_full_empty: got %b want 01", {full_ROB, empty_ROB}); end
        n_checks++;
        if ({valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free} !== '0) begin
            n_fail++; $display("FAIL reset_commit: got vc=%b rw=%0d prf=%0d free=%0d want all 0",
                               valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free);
        end
        n_checks++;
        if (ARF_tag !== ident) begin n_fail++; $display("FAIL reset_ARF: got %h want %h", ARF_tag, ident); end
        rst = 1'b1;
    endtask

    task automatic test_in_order_commit();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            valid_issue = 1'b1; Rw = AREG_W'(i); tag_PRF = TAG_W'(i + 7); tag_Rw_old = TAG_W'(i);
            step();
        end
        valid_issue = 1'b0;
        n_checks++;
        if ({tag_ROB, valid_commit, empty_ROB} !== {4'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL alloc3: got tag=%0d vc=%b empty=%b want tag=3 vc=0 empty=0",
                               tag_ROB, valid_commit, empty_ROB);
        end
        valid_Result_add = 1'b1; tag_ROB_add = 4'd1;
        step();
        valid_Result_add = 1'b0;
        n_checks++;
        if (valid_commit !== 1'b0) begin n_fail++; $display("FAIL head_not_done: got vc=%b want 0", valid_commit); end
        valid_Result_mul = 1'b1; tag_ROB_mul = 4'd0;
        step();
        valid_Result_mul = 1'b0;
        n_checks++;
        if ({valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free} !== {1'b1, 3'd1, 4'd8, 4'd1}) begin
            n_fail++; $display("FAIL commit0: got vc=%b rw=%0d prf=%0d free=%0d want 1/1/8/1",
                               valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free);
        end
        step();
        n_checks++;
        if ({valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free, ARF_tag[1]} !== {1'b1, 3'd2, 4'd9, 4'd2, 4'd8}) begin
            n_fail++; $display("FAIL commit1: got vc=%b rw=%0d prf=%0d free=%0d arf1=%0d want 1/2/9/2/8",
                               valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free, ARF_tag[1]);
        end
        step();
        n_checks++;
        if ({valid_commit, ARF_tag[2], ARF_tag[1]} !== {1'b0, 4'd9, 4'd8}) begin
            n_fail++; $display("FAIL after_commits: got vc=%b arf2=%0d arf1=%0d want 0/9/8",
                               valid_commit, ARF_tag[2], ARF_tag[1]);
        end
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            valid_issue = 1'b1; Rw = AREG_W'(i % 8); tag_PRF = TAG_W'(i + 5); tag_Rw_old = TAG_W'(15 - i);
            step();
        end
        n_checks++;
        if ({full_ROB, empty_ROB, tag_ROB} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL full16: got full=%b empty=%b tag=%0d want 1/0/0", full_ROB, empty_ROB, tag_ROB);
        end
        Rw = 3'd7; tag_PRF = 4'd3;
        step();
        valid_issue = 1'b0;
        n_checks++;
        if ({full_ROB, tag_ROB} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL drop17: got full=%b tag=%0d want 1/0", full_ROB, tag_ROB);
        end
        valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
        step();
        valid_Result_add = 1'b0;
        valid_issue = 1'b1; Rw = 3'd6; tag_PRF = 4'd12; tag_Rw_old = 4'd5;
        n_checks++;
        if ({valid_commit, full_ROB, commit_Rw, commit_tag_PRF, commit_tag_free} !== {1'b1, 1'b1, 3'd0, 4'd5, 4'd15}) begin
            n_fail++; $display("FAIL full_commit: got vc=%b full=%b rw=%0d prf=%0d free=%0d want 1/1/0/5/15",
                               valid_commit, full_ROB, commit_Rw, commit_tag_PRF, commit_tag_free);
        end
        step();
        n_checks++;
        if ({full_ROB, tag_ROB, valid_commit, ARF_tag[0]} !== {1'b0, 4'd0, 1'b0, 4'd5}) begin
            n_fail++; $display("FAIL refused_on_full: got full=%b tag=%0d vc=%b arf0=%0d want 0/0/0/5",
                               full_ROB, tag_ROB, valid_commit, ARF_tag[0]);
        end
        step();
        valid_issue = 1'b0;
        n_checks++;
        if ({full_ROB, tag_ROB} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL wrap_alloc: got full=%b tag=%0d want 1/1", full_ROB, tag_ROB);
        end
    endtask

    task automatic test_dual_completion();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            valid_issue = 1'b1; Rw = AREG_W'(i); tag_PRF = TAG_W'(i + 8); tag_Rw_old = TAG_W'(i);
            step();
        end
        valid_issue = 1'b0;
        valid_Result_add = 1'b1; tag_ROB_add = 4'd4;
        valid_Result_mul = 1'b1; tag_ROB_mul = 4'd4;
        step();
        valid_Result_mul = 1'b0; tag_ROB_add = 4'd9;
        step();
        for (int c = 0; c < 20; c++) begin
            set_idle();
            if (c < 4) begin
                valid_Result_add = (c % 2 == 0); tag_ROB_add = TAG_W'(c);
                valid_Result_mul = (c % 2 == 1); tag_ROB_mul = TAG_W'(c);
            end else if (c >= 8 && c < 12) begin
                valid_issue = 1'b1; Rw = AREG_W'(c); tag_PRF = TAG_W'(c + 1); tag_Rw_old = TAG_W'(c);
            end else if (c >= 12 && c < 16) begin
                valid_Result_add = 1'b1; tag_ROB_add = TAG_W'(c - 7);
            end
            model_expect();
            n_checks++;
            if ({valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free} !== {exp_vc, exp_rw, exp_prf, exp_free}) begin
                n_fail++; $display("FAIL dual_commit c=%0d: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", c,
                                   valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free, exp_vc, exp_rw, exp_prf, exp_free);
            end
            step();
        end
        set_idle();
        n_checks++;
        if ({valid_commit, empty_ROB, tag_ROB} !== {1'b0, 1'b0, 4'd10}) begin
            n_fail++; $display("FAIL invalid_completion_ignored: got vc=%b empty=%b tag=%0d want 0/0/10",
                               valid_commit, empty_ROB, tag_ROB);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            valid_issue      = ($urandom_range(0, 99) < 60);
            stop             = ($urandom_range(0, 99) < 15);
            Rw               = AREG_W'($urandom_range(0, AREGS - 1));
            tag_PRF          = TAG_W'($urandom);
            tag_Rw_old       = TAG_W'($urandom);
            valid_Result_add = ($urandom_range(0, 99) < 45);
            tag_ROB_add      = TAG_W'(mhead + $urandom_range(0, 19));
            valid_Result_mul = ($urandom_range(0, 99) < 35);
            tag_ROB_mul      = ($urandom_range(0, 9) == 0) ? tag_ROB_add : TAG_W'(mhead + $urandom_range(0, 19));
            model_expect();
            n_checks++;
            if ({tag_ROB, full_ROB, empty_ROB} !== {exp_tag, exp_full, exp_empty}) begin
                n_fail++; $display("FAIL rand_status c=%0d: got tag=%0d full=%b empty=%b want tag=%0d full=%b empty=%b",
                                   c, tag_ROB, full_ROB, empty_ROB, exp_tag, exp_full, exp_empty);
            end
            n_checks++;
            if ({valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free} !== {exp_vc, exp_rw, exp_prf, exp_free}) begin
                n_fail++; $display("FAIL rand_commit c=%0d: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", c,
                                   valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free, exp_vc, exp_rw, exp_prf, exp_free);
            end
            n_checks++;
            if (ARF_tag !== exp_arf) begin
                n_fail++; $display("FAIL rand_ARF c=%0d: got %h want %h", c, ARF_tag, exp_arf);
            end
            step();
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            valid_issue = 1'b1; Rw = AREG_W'(i); tag_PRF = TAG_W'(i + 10); tag_Rw_old = TAG_W'(i);
            if (i == 2) begin valid_Result_add = 1'b1; tag_ROB_add = 4'd0; end
            else if (i == 3) begin valid_Result_add = 1'b1; tag_ROB_add = 4'd1; end
            else valid_Result_add = 1'b0;
            step();
        end
        set_idle();
        step();
        model_expect();
        n_checks++;
        if ({tag_ROB, empty_ROB, ARF_tag} !== {exp_tag, 1'b0, exp_arf} || exp_arf === ident) begin
            n_fail++; $display("FAIL pre_reset_state: got tag=%0d empty=%b arf=%h want tag=%0d empty=0 arf=%h (non-identity)",
                               tag_ROB, empty_ROB, ARF_tag, exp_tag, exp_arf);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({tag_ROB, full_ROB, empty_ROB, valid_commit, commit_Rw, commit_tag_PRF, commit_tag_free} !==
            {4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 4'd0}) begin
            n_fail++; $display("FAIL async_reset_outputs: got tag=%0d full=%b empty=%b vc=%b want 0/0/1/0",
                               tag_ROB, full_ROB, empty_ROB, valid_commit);
        end
        n_checks++;
        if (ARF_tag !== ident) begin n_fail++; $display("FAIL async_reset_ARF: got %h want %h", ARF_tag, ident); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_issue = 1'b1; Rw = 3'd4; tag_PRF = 4'd13; tag_Rw_old = 4'd4;
        step();
        set_idle();
        n_checks++;
        if ({tag_ROB, empty_ROB} !== {4'd1, 1'b0}) begin
            n_fail++; $display("FAIL post_reset_alloc: got tag=%0d empty=%b want 1/0", tag_ROB, empty_ROB);
        end
    endtask

    initial begin
        for (int i = 0; i < AREGS; i++) ident[i] = TAG_W'(i);
        test_reset();
        test_in_order_commit();
        test_full_and_wrap();
        test_dual_completion();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
